// File: rtl/pipelined_array_multiplier_pkg.sv
// Shared constants and helpers for the pipelined array multiplier.
// Signed (Baugh-Wooley) operation is selected with the SIGNED_MODE_EN macro.
package pipelined_array_multiplier_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;
  localparam int MAX_TAG_W = 16;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/array_mult_row.sv
// One combinational carry-save row: folds partial-product row ROW into (sum, carry).
// With SIGNED_MODE_EN defined, the Baugh-Wooley MSB row/column bits are inverted.
module array_mult_row
  import pipelined_array_multiplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 0
) (
  input  logic [WIDTH-1:0]             i_a,
  input  logic                         i_b_bit,
  input  logic [prod_width(WIDTH)-1:0] i_sum,
  input  logic [prod_width(WIDTH)-1:0] i_carry,
  output logic [prod_width(WIDTH)-1:0] o_sum,
  output logic [prod_width(WIDTH)-1:0] o_carry
);

  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] w_pp_bits;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_maj;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
`ifdef SIGNED_MODE_EN
      // Invert bits where exactly one of (column, row) is the sign position.
      if ((gi == WIDTH - 1) != (ROW == WIDTH - 1)) begin : g_inv
        assign w_pp_bits[gi] = ~(i_a[gi] & i_b_bit);
      end else begin : g_pos
        assign w_pp_bits[gi] = i_a[gi] & i_b_bit;
      end
`else
      assign w_pp_bits[gi] = i_a[gi] & i_b_bit;
`endif
    end
  endgenerate

  assign w_pp    = {{WIDTH{1'b0}}, w_pp_bits} << ROW;
  assign o_sum   = i_sum ^ i_carry ^ w_pp;
  assign w_maj   = (i_sum & i_carry) | (i_sum & w_pp) | (i_carry & w_pp);
  assign o_carry = w_maj << 1;

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Fully pipelined WIDTHxWIDTH array multiplier with valid/ready, tag pass-through,
// and optional two's-complement mode (SIGNED_MODE_EN). Latency WIDTH+1 edges.
module pipelined_array_multiplier
  import pipelined_array_multiplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [prod_width(WIDTH)-1:0] p,
  output logic [TAG_W-1:0]             out_tag
);

  localparam int PW = prod_width(WIDTH);
  localparam logic [PW-1:0] ONE = 1;
`ifdef SIGNED_MODE_EN
  localparam logic [PW-1:0] CORR = (ONE << WIDTH) | (ONE << (PW - 1));
`else
  localparam logic [PW-1:0] CORR = '0;
`endif

  logic w_adv;

  // Operand capture register feeding row 0.
  logic             r_in_valid;
  logic [WIDTH-1:0] r_in_a;
  logic [WIDTH-1:0] r_in_b;
  logic [TAG_W-1:0] r_in_tag;

  // Carry-save row stages; the last stage needs no a/b any more.
  logic             r_valid [WIDTH];
  logic [PW-1:0]    r_sum   [WIDTH];
  logic [PW-1:0]    r_carry [WIDTH];
  logic [TAG_W-1:0] r_tag   [WIDTH];
  logic [WIDTH-1:0] r_a     [WIDTH-1];
  logic [WIDTH-1:0] r_b     [WIDTH-1];

  logic             r_out_valid;
  logic [PW-1:0]    r_p;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_pre_valid [WIDTH];
  logic [WIDTH-1:0] w_pre_a     [WIDTH];
  logic [WIDTH-1:0] w_pre_b     [WIDTH];
  logic [PW-1:0]    w_pre_sum   [WIDTH];
  logic [PW-1:0]    w_pre_carry [WIDTH];
  logic [TAG_W-1:0] w_pre_tag   [WIDTH];
  logic [PW-1:0]    w_row_sum   [WIDTH];
  logic [PW-1:0]    w_row_carry [WIDTH];

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign out_tag   = r_out_tag;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // Signed-mode correction constants enter as the initial carry vector.
        assign w_pre_valid[gi] = r_in_valid;
        assign w_pre_a[gi]     = r_in_a;
        assign w_pre_b[gi]     = r_in_b;
        assign w_pre_sum[gi]   = '0;
        assign w_pre_carry[gi] = CORR;
        assign w_pre_tag[gi]   = r_in_tag;
      end else begin : g_next
        assign w_pre_valid[gi] = r_valid[gi-1];
        assign w_pre_a[gi]     = r_a[gi-1];
        assign w_pre_b[gi]     = r_b[gi-1];
        assign w_pre_sum[gi]   = r_sum[gi-1];
        assign w_pre_carry[gi] = r_carry[gi-1];
        assign w_pre_tag[gi]   = r_tag[gi-1];
      end

      array_mult_row #(
        .WIDTH (WIDTH),
        .ROW   (gi)
      ) u_row (
        .i_a     (w_pre_a[gi]),
        .i_b_bit (w_pre_b[gi][0]),
        .i_sum   (w_pre_sum[gi]),
        .i_carry (w_pre_carry[gi]),
        .o_sum   (w_row_sum[gi]),
        .o_carry (w_row_carry[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_a     <= '0;
      r_in_b     <= '0;
      r_in_tag   <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        r_valid[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_carry[k] <= '0;
        r_tag[k]   <= '0;
      end
      for (int k = 0; k < WIDTH - 1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_out_tag   <= '0;
    end else if (w_adv) begin
      r_in_valid <= in_valid;
      r_in_a     <= a;
      r_in_b     <= b;
      r_in_tag   <= in_tag;
      for (int k = 0; k < WIDTH; k++) begin
        r_valid[k] <= w_pre_valid[k];
        r_sum[k]   <= w_row_sum[k];
        r_carry[k] <= w_row_carry[k];
        r_tag[k]   <= w_pre_tag[k];
      end
      // Each stage consumes the low multiplier bit and passes the rest on.
      for (int k = 0; k < WIDTH - 1; k++) begin
        r_a[k] <= w_pre_a[k];
        r_b[k] <= w_pre_b[k] >> 1;
      end
      r_out_valid <= r_valid[WIDTH-1];
      r_p         <= r_sum[WIDTH-1] + r_carry[WIDTH-1];
      r_out_tag   <= r_tag[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed self-checking bench for pipelined_array_multiplier (WIDTH=8, TAG_W=4).
// Builds with or without SIGNED_MODE_EN; directed vectors are chosen per mode.
module tb_pipelined_array_multiplier;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int LAT   = WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic [TAG_W-1:0]     out_tag;

  pipelined_array_multiplier #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    logic [TAG_W-1:0]   tag;
    int                 acc_edge;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   lat_check = 1'b0;
  int   pop_cnt;
  int   first_pop_edge;
  int   last_pop_edge;
  logic [2*WIDTH-1:0] stall_p;
  logic [TAG_W-1:0]   stall_tag;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SIGNED_MODE_EN
    logic signed [2*WIDTH-1:0] r;
    r = $signed(x) * $signed(y);
    return r;
`else
    return {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
`endif
  endfunction

  // One clock cycle: drive at negedge, observe, account for both handshakes.
  task automatic do_cycle(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [TAG_W-1:0] tg, input logic ordy,
                          input logic [2*WIDTH-1:0] exp_p);
    in_valid  = v;
    a         = av;
    b         = bv;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("stale_product", {31'd0, out_valid}, 32'd0);
      end else begin
        $display("txn out tag=%0d p=0x%0h edge=%0d", out_tag, p, edge_cnt);
        check("product", {16'd0, p}, {16'd0, q[0].p});
        check("out_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
        if (lat_check) check("latency", edge_cnt - q[0].acc_edge, LAT);
        if (pop_cnt == 0) first_pop_edge = edge_cnt;
        last_pop_edge = edge_cnt;
        pop_cnt++;
        void'(q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      exp_t e;
      e.p        = exp_p;
      e.tag      = tg;
      e.acc_edge = edge_cnt + 1;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) do_cycle(1'b0, '0, '0, '0, 1'b1, '0);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic single(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [TAG_W-1:0] tg, input logic [2*WIDTH-1:0] exp_p);
    lat_check = 1'b1;
    do_cycle(1'b1, av, bv, tg, 1'b1, exp_p);
    drain();
    lat_check = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    pop_cnt   = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_p", {16'd0, p}, 32'd0);
    check("reset_out_tag", {28'd0, out_tag}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed single operations with hand-computed products.
`ifdef SIGNED_MODE_EN
    single(8'h80, 8'h80, 4'd1, 16'h4000);
    single(8'hFF, 8'h01, 4'd2, 16'hFFFF);
    single(8'h7F, 8'h80, 4'd3, 16'hC080);
    single(8'h00, 8'hFF, 4'd4, 16'h0000);
`else
    single(8'hFF, 8'hFF, 4'd3, 16'hFE01);
    single(8'h00, 8'hFF, 4'd4, 16'h0000);
    single(8'h0C, 8'h0D, 4'd5, 16'h009C);
`endif

    // Back-to-back stream a=i, b=255-i.
    pop_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      av = i[7:0];
      bv = 8'(255 - i);
      do_cycle(1'b1, av, bv, i[3:0], 1'b1, model(av, bv));
    end
    drain();
    check("stream_count", pop_cnt, 256);
    check("stream_consecutive", last_pop_edge - first_pop_edge, 255);

    // Backpressure: fill, stall 5 cycles, release.
    pop_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      av = 8'(k + 10);
      bv = 8'(k * 7 + 1);
      do_cycle(1'b1, av, bv, 4'(k + 6), 1'b1, model(av, bv));
    end
    stall_p   = q[0].p;
    stall_tag = q[0].tag;
    for (int s = 0; s < 5; s++) begin
      in_valid  = 1'b1;
      a         = 8'hAA;
      b         = 8'h55;
      out_ready = 1'b0;
      #1;
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_p", {16'd0, p}, {16'd0, stall_p});
      check("stall_tag", {28'd0, out_tag}, {28'd0, stall_tag});
      do_cycle(1'b1, 8'hAA, 8'h55, 4'hF, 1'b0, model(8'hAA, 8'h55));
    end
    drain();
    check("backpressure_count", pop_cnt, 10);

    // Reset with four operations in flight.
    for (int k = 0; k < 4; k++) do_cycle(1'b1, 8'(k + 1), 8'(k + 2), 4'(k), 1'b1, '0);
    rst = 1'b1;
    do_cycle(1'b0, '0, '0, '0, 1'b1, '0);
    rst = 1'b0;
    q.delete();
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_p", {16'd0, p}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 15; k++) do_cycle(1'b0, '0, '0, '0, 1'b1, '0);
    single(8'd3, 8'd5, 4'd9, 16'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
